ucie_ctl_adapter_rdi_cfg_link: RTL and testbench

Adapter-side (LP) end of the RDI sideband configuration channel; the counterpart of the PHY's pl_cfg/lp_cfg logic.
- TX path: takes NC-bit messages from the adapter core and drives lp_cfg/lp_cfg_valid, gated by a credit counter replenished by pl_cfg_crd.
- RX path: captures pl_cfg/pl_cfg_vld into a FIFO, presents messages to the adapter core, and returns one lp_cfg_crd pulse per consumed message.
- Placement: sits between the adapter core and the RDI, one instance per die.

---
 rtl/ucie_ctl_adapter_rdi_cfg_link.sv | 106 ++++++++++
 tb/tb_ucie_ctl_adapter_rdi_cfg_link.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ucie_ctl_adapter_rdi_cfg_link.sv
// ucie_ctl_adapter_rdi_cfg_link: adapter-side RDI sideband config channel (credited TX, FIFO RX with credit return)
module ucie_ctl_adapter_rdi_cfg_link #(
  parameter int NC         = 32,
  parameter int TX_CREDITS = 4,
  parameter int RX_DEPTH   = 4,
  parameter int CNT_W      = $clog2((TX_CREDITS > RX_DEPTH ? TX_CREDITS : RX_DEPTH) + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_credit_reinit,
  input  logic [NC-1:0]    i_tx_msg,
  input  logic             i_tx_msg_valid,
  output logic             o_tx_msg_ready,
  output logic [NC-1:0]    o_rdi_lp_cfg,
  output logic             o_rdi_lp_cfg_valid,
  input  logic             i_rdi_pl_cfg_crd,
  input  logic [NC-1:0]    i_rdi_pl_cfg,
  input  logic             i_rdi_pl_cfg_vld,
  output logic             o_rdi_lp_cfg_crd,
  output logic [NC-1:0]    o_rx_msg,
  output logic             o_rx_msg_valid,
  input  logic             i_rx_msg_ready,
  output logic [CNT_W-1:0] o_tx_credits,
  output logic [CNT_W-1:0] o_rx_count,
  output logic             o_err_credit_overflow,
  output logic             o_err_rx_overflow
);
  localparam int PW = RX_DEPTH > 1 ? $clog2(RX_DEPTH) : 1;
  localparam logic [CNT_W-1:0] TXC = CNT_W'(TX_CREDITS);
  localparam logic [CNT_W-1:0] RXD = CNT_W'(RX_DEPTH);
  localparam logic [PW-1:0] LAST = PW'(RX_DEPTH - 1);

  logic [CNT_W-1:0] cred_q, cred_d, cnt_q, cnt_d;
  logic [PW-1:0]    wr_q, rd_q;
  logic [NC-1:0]    mem_q [RX_DEPTH];
  logic [NC-1:0]    lp_cfg_q;
  logic             lp_vld_q, crd_q, err_cr_q, err_rx_q;
  logic             send, pop, full, push, rx_ovf, cr_ovf;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == LAST ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    send   = i_tx_msg_valid & (cred_q != '0);
    cr_ovf = i_rdi_pl_cfg_crd & ~send & (cred_q == TXC);
    cred_d = (send & ~i_rdi_pl_cfg_crd) ? cred_q - CNT_W'(1) :
             (i_rdi_pl_cfg_crd & ~send & ~cr_ovf) ? cred_q + CNT_W'(1) : cred_q;
    pop    = (cnt_q != '0) & i_rx_msg_ready;
    full   = cnt_q == RXD;
    // a full FIFO still takes a push when the head leaves in the same cycle
    push   = i_rdi_pl_cfg_vld & (~full | pop);
    rx_ovf = i_rdi_pl_cfg_vld & full & ~pop;
    cnt_d  = (push & ~pop) ? cnt_q + CNT_W'(1) : (pop & ~push) ? cnt_q - CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cred_q   <= TXC;
      cnt_q    <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      mem_q    <= '{default: '0};
      lp_cfg_q <= '0;
      lp_vld_q <= 1'b0;
      crd_q    <= 1'b0;
      err_cr_q <= 1'b0;
      err_rx_q <= 1'b0;
    end else if (i_credit_reinit) begin
      cred_q   <= TXC;
      cnt_q    <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      lp_vld_q <= 1'b0;
      crd_q    <= 1'b0;
      err_cr_q <= 1'b0;
      err_rx_q <= 1'b0;
    end else begin
      cred_q   <= cred_d;
      cnt_q    <= cnt_d;
      lp_vld_q <= send;
      crd_q    <= pop;
      err_cr_q <= err_cr_q | cr_ovf;
      err_rx_q <= err_rx_q | rx_ovf;
      if (send) lp_cfg_q <= i_tx_msg;
      if (push) begin
        mem_q[wr_q] <= i_rdi_pl_cfg;
        wr_q        <= nxt(wr_q);
      end
      if (pop) rd_q <= nxt(rd_q);
    end
  end

  always_comb begin
    o_tx_msg_ready        = cred_q != '0;
    o_rdi_lp_cfg          = lp_cfg_q;
    o_rdi_lp_cfg_valid    = lp_vld_q;
    o_rdi_lp_cfg_crd      = crd_q;
    o_rx_msg              = mem_q[rd_q];
    o_rx_msg_valid        = cnt_q != '0;
    o_tx_credits          = cred_q;
    o_rx_count            = cnt_q;
    o_err_credit_overflow = err_cr_q;
    o_err_rx_overflow     = err_rx_q;
  end
endmodule

// File: tb/tb_ucie_ctl_adapter_rdi_cfg_link.sv
// tb_ucie_ctl_adapter_rdi_cfg_link: scoreboard bench with a queue-based reference model
module tb_ucie_ctl_adapter_rdi_cfg_link;
  localparam int NC = 32, TXC = 4, RXD = 4, CW = 3;

  logic clk = 0, rst_n = 0;
  logic ri = 0, tv = 0, pcrd = 0, pv = 0, rr = 0;
  logic [NC-1:0] tm = '0, pw = '0;
  logic tx_ready, lp_vld, lp_crd, rx_vld, e_cr, e_rx;
  logic [NC-1:0] lp_cfg, rx_msg;
  logic [CW-1:0] tx_cred, rx_cnt;

  int checks = 0, errors = 0;

  int m_cred = TXC;
  bit m_lpv = 0, m_crd = 0, m_ecr = 0, m_erx = 0;
  logic [NC-1:0] txq[$], rxq[$];

  ucie_ctl_adapter_rdi_cfg_link #(.NC(NC), .TX_CREDITS(TXC), .RX_DEPTH(RXD)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_credit_reinit(ri),
    .i_tx_msg(tm), .i_tx_msg_valid(tv), .o_tx_msg_ready(tx_ready),
    .o_rdi_lp_cfg(lp_cfg), .o_rdi_lp_cfg_valid(lp_vld),
    .i_rdi_pl_cfg_crd(pcrd), .i_rdi_pl_cfg(pw), .i_rdi_pl_cfg_vld(pv),
    .o_rdi_lp_cfg_crd(lp_crd), .o_rx_msg(rx_msg), .o_rx_msg_valid(rx_vld),
    .i_rx_msg_ready(rr), .o_tx_credits(tx_cred), .o_rx_count(rx_cnt),
    .o_err_credit_overflow(e_cr), .o_err_rx_overflow(e_rx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [NC-1:0] act, input logic [NC-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  // reference model: credits as an integer, RX FIFO as a bounded queue
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cred = TXC; m_lpv = 0; m_crd = 0; m_ecr = 0; m_erx = 0;
      txq.delete(); rxq.delete();
    end else if (ri) begin
      m_cred = TXC; m_lpv = 0; m_crd = 0; m_ecr = 0; m_erx = 0;
      txq.delete(); rxq.delete();
    end else begin
      bit s, p;
      s = tv && m_cred > 0;
      m_lpv = s;
      if (s) txq.push_back(tm);
      if (pcrd && !s && m_cred == TXC) m_ecr = 1;
      m_cred = m_cred - int'(s) + int'(pcrd);
      if (m_cred > TXC) m_cred = TXC;
      p = rxq.size() > 0 && rr;
      m_crd = p;
      if (p) void'(rxq.pop_front());
      if (pv) begin
        if (rxq.size() < RXD) rxq.push_back(pw);
        else m_erx = 1;
      end
    end
  end

  // monitor: compares DUT outputs against the model mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      chk("mon_credits", NC'(tx_cred), NC'(m_cred));
      chk("mon_ready", NC'(tx_ready), NC'(m_cred != 0));
      chk("mon_rx_count", NC'(rx_cnt), NC'(rxq.size()));
      chk("mon_rx_valid", NC'(rx_vld), NC'(rxq.size() != 0));
      chk("mon_lp_valid", NC'(lp_vld), NC'(m_lpv));
      chk("mon_lp_crd", NC'(lp_crd), NC'(m_crd));
      chk("mon_err_cr", NC'(e_cr), NC'(m_ecr));
      chk("mon_err_rx", NC'(e_rx), NC'(m_erx));
      if (lp_vld) begin
        if (txq.size() == 0) chk("mon_tx_unexpected", NC'(1), NC'(0));
        else chk("mon_tx_data", lp_cfg, txq.pop_front());
      end
      if (rx_vld && rxq.size() > 0) chk("mon_rx_head", rx_msg, rxq[0]);
    end
  end

  task automatic step(input logic v, input logic [NC-1:0] m, input logic c,
                      input logic p, input logic [NC-1:0] w, input logic r, input logic re);
    tv = v; tm = m; pcrd = c; pv = p; pw = w; rr = r; ri = re;
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    step(0, '0, 0, 0, '0, 0, 0);
  endtask

  initial begin
    @(posedge clk); #2;
    chk("rst_credits", NC'(tx_cred), NC'(TXC));
    chk("rst_ready", NC'(tx_ready), NC'(1));
    chk("rst_lp_valid", NC'(lp_vld), NC'(0));
    chk("rst_rx_valid", NC'(rx_vld), NC'(0));
    chk("rst_errs", NC'({e_cr, e_rx, lp_crd}), NC'(0));
    rst_n = 1;
    @(posedge clk); #2;
    for (int i = 0; i < 4; i++) begin
      step(1, NC'(32'hA0 + i), 0, 0, '0, 0, 0);
      chk("tx_exh_data", lp_cfg, NC'(32'hA0 + i));
    end
    step(1, NC'(32'hA4), 0, 0, '0, 0, 0);
    chk("tx_exh_ready", NC'(tx_ready), NC'(0));
    chk("tx_exh_credits", NC'(tx_cred), NC'(0));
    chk("tx_exh_novalid", NC'(lp_vld), NC'(0));
    step(1, NC'(32'hA4), 1, 0, '0, 0, 0);
    chk("tx_crd_return", NC'(tx_cred), NC'(1));
    step(1, NC'(32'hA4), 0, 0, '0, 0, 0);
    chk("tx_a4_sent", NC'({lp_vld, lp_cfg}), NC'({1'b1, 32'hA4}));
    step(0, '0, 1, 0, '0, 0, 0);
    step(0, '0, 1, 0, '0, 0, 0);
    step(1, NC'(32'hB1), 1, 0, '0, 0, 0);
    chk("sim_send_crd_cred", NC'(tx_cred), NC'(2));
    chk("sim_send_crd_vld", NC'(lp_vld), NC'(1));
    step(0, '0, 1, 0, '0, 0, 0);
    step(0, '0, 1, 0, '0, 0, 0);
    chk("ovf_pre", NC'(e_cr), NC'(0));
    step(0, '0, 1, 0, '0, 0, 0);
    chk("ovf_credits", NC'(tx_cred), NC'(TXC));
    chk("ovf_flag", NC'(e_cr), NC'(1));
    idle();
    chk("ovf_sticky", NC'(e_cr), NC'(1));
    step(0, '0, 0, 1, NC'(32'h11), 0, 0);
    step(0, '0, 0, 1, NC'(32'h22), 0, 0);
    step(0, '0, 0, 1, NC'(32'h33), 0, 0);
    chk("rx_count3", NC'(rx_cnt), NC'(3));
    chk("rx_head11", rx_msg, NC'(32'h11));
    step(0, '0, 0, 0, '0, 1, 0);
    chk("rx_pop1", NC'({lp_crd, rx_msg[7:0]}), NC'({1'b1, 8'h22}));
    step(0, '0, 0, 0, '0, 1, 0);
    chk("rx_pop2", NC'({lp_crd, rx_msg[7:0]}), NC'({1'b1, 8'h33}));
    step(0, '0, 0, 0, '0, 1, 0);
    chk("rx_pop3", NC'({lp_crd, rx_cnt}), NC'({1'b1, 3'd0}));
    idle();
    chk("rx_crd_end", NC'(lp_crd), NC'(0));
    for (int i = 1; i <= 4; i++) step(0, '0, 0, 1, NC'(32'h40 + i), 0, 0);
    step(0, '0, 0, 1, NC'(32'h55), 0, 0);
    chk("rxovf_flag", NC'(e_rx), NC'(1));
    chk("rxovf_count", NC'(rx_cnt), NC'(4));
    step(0, '0, 0, 1, NC'(32'h66), 1, 0);
    chk("full_pushpop_count", NC'(rx_cnt), NC'(4));
    for (int i = 0; i < 3; i++) step(0, '0, 0, 0, '0, 1, 0);
    chk("wrap_head66", rx_msg, NC'(32'h66));
    step(0, '0, 0, 0, '0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, NC'(32'hA7 + i), 0, 0, '0, 0, 0);
    step(0, '0, 0, 1, NC'(32'h77), 0, 0);
    step(0, '0, 0, 1, NC'(32'h78), 0, 0);
    chk("pre_reinit", NC'({tx_cred, rx_cnt, e_cr, e_rx}), NC'({3'd1, 3'd2, 2'b11}));
    step(1, NC'(32'hAA), 1, 1, NC'(32'h99), 1, 1);
    chk("reinit_state", NC'({tx_cred, rx_cnt, lp_vld, lp_crd, e_cr, e_rx}),
        NC'({3'd4, 3'd0, 4'b0000}));
    step(1, NC'(32'hC0), 0, 0, '0, 0, 0);
    chk("arst_pre", NC'(lp_vld), NC'(1));
    #1 rst_n = 0;
    #1 chk("arst_valid", NC'(lp_vld), NC'(0));
    chk("arst_credits", NC'(tx_cred), NC'(TXC));
    tv = 0;
    @(posedge clk); #2 rst_n = 1;
    for (int i = 0; i < 2000; i++)
      step(1'($urandom % 2), $urandom, 1'($urandom % 4 == 0), 1'($urandom % 2),
           $urandom, 1'($urandom % 3 != 0), 1'($urandom % 150 == 0));
    idle();
    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
